// File: rtl/sprite_painter_pkg.sv
// Shared types and defaults for the sprite painter.
// Slot records, pixel type, FSM states and pipeline entries.
package sprite_painter_pkg;

  localparam int RENDER_SLOTS = 32;
  localparam int FB_WIDTH     = 1280;
  localparam int FB_HEIGHT    = 300;
  localparam int SHEET_WIDTH  = 2448;
  localparam int ROM_LATENCY  = 2;
  localparam int AW           = 19;

  typedef logic [1:0] pixel_t;

  localparam pixel_t TRANSPARENT = 2'b00;
  localparam pixel_t BG_PIXEL    = 2'b00;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
  } sprite_t;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
  } pos_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LATCH,
    DRAW,
    NEXT,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic          inb;
  } pix_t;

  function automatic logic [AW-1:0] sext(
    input logic [11:0] v
  );
    return {{(AW-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/sprite_painter_pixel_pipe.sv
// Delay line pairing each ROM read with its framebuffer target.
// Ports: issue/issue_addr/issue_inb in, clr/clr_addr in, rom_data in, fb_we/fb_addr/fb_data out.
module sprite_painter_pixel_pipe
  import sprite_painter_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [AW-1:0] issue_addr,
  input  logic          issue_inb,
  input  logic          clr,
  input  logic [AW-1:0] clr_addr,
  input  pixel_t        rom_data,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output pixel_t        fb_data
);

  pix_t pipe_q [LATENCY];
  pix_t tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= {issue, issue_addr, issue_inb};
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tail = pipe_q[LATENCY-1];

  // Clear and draw never overlap: the line is empty while clearing.
  always_comb begin
    fb_we   = 1'b0;
    fb_addr = tail.addr;
    fb_data = BG_PIXEL;
    if (clr) begin
      fb_we   = 1'b1;
      fb_addr = clr_addr;
    end else if (tail.valid) begin
      fb_data = rom_data;
      fb_we   = tail.inb && (rom_data != TRANSPARENT);
    end
  end

endmodule

// File: rtl/sprite_painter.sv
// Clears the framebuffer, then blits every render slot from the sheet ROM.
// Ports: clk, rst, frame_start, sprite[], pos[], rom_addr/rom_data, fb_addr/fb_data/fb_we, painter_finished.
module sprite_painter
  import sprite_painter_pkg::*;
#(
  parameter int FB_WIDTH    = sprite_painter_pkg::FB_WIDTH,
  parameter int FB_HEIGHT   = sprite_painter_pkg::FB_HEIGHT,
  parameter int SHEET_WIDTH = sprite_painter_pkg::SHEET_WIDTH,
  parameter int ROM_LATENCY = sprite_painter_pkg::ROM_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  sprite_t [RENDER_SLOTS-1:0] sprite,
  input  pos_t    [RENDER_SLOTS-1:0] pos,
  output logic    [AW-1:0]           rom_addr,
  input  pixel_t                     rom_data,
  output logic    [AW-1:0]           fb_addr,
  output pixel_t                     fb_data,
  output logic                       fb_we,
  output logic                       painter_finished
);

  localparam int SLOT_W = $clog2(RENDER_SLOTS);
  localparam int DR_W   = $clog2(ROM_LATENCY + 1);

  localparam logic [AW-1:0] LAST_PIX =
    AW'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [AW-1:0] SW = AW'(SHEET_WIDTH);
  localparam logic [AW-1:0] FW = AW'(FB_WIDTH);

  state_t state, state_n;

  logic [SLOT_W-1:0] slot;
  logic [AW-1:0]     clr_cnt;
  logic [DR_W-1:0]   drain_cnt;
  logic [11:0]       w, h, col, row;
  logic [12:0]       x0, dx, dy;
  logic [AW-1:0]     src_row, src_ptr;
  logic [AW-1:0]     dst_row, dst_ptr;
  logic              fin;

  sprite_t       spr;
  pos_t          ps;
  logic [AW-1:0] src0, dst0;
  logic          start_ok;
  logic          last_col, last_row;
  logic          in_bounds;

  assign spr = sprite[slot];
  assign ps  = pos[slot];

  // Only the two corner addresses need a constant multiply;
  // rows after that advance by addition.
  assign src0 = AW'(spr.y) * SW + AW'(spr.x);
  assign dst0 = sext(ps.y) * FW + sext(ps.x);

  assign start_ok = frame_start &&
    (state == IDLE || state == DONE);
  assign last_col = (col == w - 12'd1);
  assign last_row = (row == h - 12'd1);

  // dx/dy carry a sign in bit 12; negative is off-screen.
  assign in_bounds =
    !dx[12] && (dx[11:0] < 12'(FB_WIDTH)) &&
    !dy[12] && (dy[11:0] < 12'(FB_HEIGHT));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE:
        state_n = frame_start ? CLEAR : IDLE;
      CLEAR:
        if (clr_cnt == LAST_PIX) state_n = LATCH;
      LATCH:
        state_n = (spr.w == '0 || spr.h == '0) ?
          NEXT : DRAW;
      DRAW:
        if (last_col && last_row) state_n = NEXT;
      NEXT:
        state_n = (slot == SLOT_W'(RENDER_SLOTS-1)) ?
          DRAIN : LATCH;
      DRAIN:
        if (drain_cnt == DR_W'(ROM_LATENCY-1))
          state_n = DONE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      clr_cnt   <= '0;
      drain_cnt <= '0;
      w         <= '0;
      h         <= '0;
      col       <= '0;
      row       <= '0;
      x0        <= '0;
      dx        <= '0;
      dy        <= '0;
      src_row   <= '0;
      src_ptr   <= '0;
      dst_row   <= '0;
      dst_ptr   <= '0;
      fin       <= 1'b0;
    end else begin
      state <= state_n;
      if (start_ok) fin <= 1'b0;
      else if (state_n == DONE) fin <= 1'b1;
      unique case (state)
        CLEAR: begin
          clr_cnt <= (clr_cnt == LAST_PIX) ?
            '0 : clr_cnt + AW'(1);
          slot    <= '0;
        end
        LATCH: begin
          w       <= spr.w;
          h       <= spr.h;
          col     <= '0;
          row     <= '0;
          x0      <= {ps.x[11], ps.x};
          dx      <= {ps.x[11], ps.x};
          dy      <= {ps.y[11], ps.y};
          src_row <= src0;
          src_ptr <= src0;
          dst_row <= dst0;
          dst_ptr <= dst0;
        end
        DRAW: begin
          if (last_col) begin
            col     <= '0;
            row     <= row + 12'd1;
            dx      <= x0;
            dy      <= dy + 13'd1;
            src_row <= src_row + SW;
            src_ptr <= src_row + SW;
            dst_row <= dst_row + FW;
            dst_ptr <= dst_row + FW;
          end else begin
            col     <= col + 12'd1;
            dx      <= dx + 13'd1;
            src_ptr <= src_ptr + AW'(1);
            dst_ptr <= dst_ptr + AW'(1);
          end
        end
        NEXT: begin
          slot      <= slot + SLOT_W'(1);
          drain_cnt <= '0;
        end
        DRAIN:
          drain_cnt <= drain_cnt + DR_W'(1);
        default: ;
      endcase
    end
  end

  assign rom_addr         = src_ptr;
  assign painter_finished = fin;

  sprite_painter_pixel_pipe #(
    .LATENCY (ROM_LATENCY)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue      (state == DRAW),
    .issue_addr (dst_ptr),
    .issue_inb  (in_bounds),
    .clr        (state == CLEAR),
    .clr_addr   (clr_cnt),
    .rom_data   (rom_data),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data)
  );

endmodule

// File: tb/tb_sprite_painter.sv
// Self-checking bench for sprite_painter on a reduced framebuffer.
// Reference image is painted slot by slot from the sheet ROM model.
`timescale 1ns/1ps
module tb_sprite_painter;
  import sprite_painter_pkg::*;

  localparam int W    = 96;
  localparam int H    = 64;
  localparam int NPIX = W * H;
  localparam int SW   = SHEET_WIDTH;
  localparam int L    = ROM_LATENCY;
  localparam int RS   = RENDER_SLOTS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  sprite_t [RS-1:0] sprite;
  pos_t    [RS-1:0] pos;
  logic [AW-1:0] rom_addr, fb_addr;
  pixel_t rom_data, fb_data;
  logic fb_we, painter_finished;

  sprite_painter #(
    .FB_WIDTH  (W),
    .FB_HEIGHT (H)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .sprite           (sprite),
    .pos              (pos),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .fb_addr          (fb_addr),
    .fb_data          (fb_data),
    .fb_we            (fb_we),
    .painter_finished (painter_finished)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  // Sheet ROM: mode 1 punches a transparent checkerboard
  // into every sheet column at or beyond x=1000.
  int rom_mode = 0;

  function automatic pixel_t rom_fn(input logic [AW-1:0] a,
                                    input int mode);
    int ia, c, r;
    ia = int'(a);
    c  = ia % SW;
    r  = ia / SW;
    if (mode == 1 && c >= 1000 && ((c + r) % 2) == 1)
      return TRANSPARENT;
    return pixel_t'((ia * 7 + r) % 3 + 1);
  endfunction

  logic [AW-1:0] rd_q [L];

  always @(posedge clk) begin
    rd_q[0] <= rom_addr;
    for (int i = 1; i < L; i++) rd_q[i] <= rd_q[i-1];
  end

  assign rom_data = rom_fn(rd_q[L-1], rom_mode);

  // Write monitor: captured image plus per-frame statistics.
  pixel_t cap [NPIX];
  int cyc = 0;
  int wr_idx = 0;
  int clr_bad = 0;
  int first_draw = -1;
  int last_draw = -1;
  int oob = 0;
  int rises = 0;
  int rise_cyc = 0;
  logic arm = 1'b0;
  logic arm_seen = 1'b0;
  logic fin_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (arm != arm_seen) begin
      arm_seen = arm;
      for (int i = 0; i < NPIX; i++) cap[i] = 2'b11;
      wr_idx = 0;
      clr_bad = 0;
      first_draw = -1;
      last_draw = -1;
    end
    if (fb_we) begin
      if (int'(fb_addr) >= NPIX) oob++;
      else cap[fb_addr] = fb_data;
      if (wr_idx < NPIX) begin
        if (int'(fb_addr) != wr_idx || fb_data != BG_PIXEL)
          clr_bad++;
      end else begin
        if (wr_idx == NPIX) first_draw = int'(fb_addr);
        last_draw = int'(fb_addr);
      end
      wr_idx++;
    end
    if (painter_finished && !fin_d) begin
      rises++;
      rise_cyc = cyc;
    end
    fin_d = painter_finished;
  end

  // Slot table and reference model.
  int sx [RS];
  int sy [RS];
  int sw [RS];
  int sh [RS];
  int px [RS];
  int py [RS];
  pixel_t mdl [NPIX];
  int exp_draw;
  int sum_wh;

  task automatic clear_slots;
    for (int i = 0; i < RS; i++) begin
      sx[i] = 0; sy[i] = 0; sw[i] = 0;
      sh[i] = 0; px[i] = 0; py[i] = 0;
    end
  endtask

  task automatic set_slot(input int s, input int x,
                          input int y, input int ww,
                          input int hh, input int ox,
                          input int oy);
    sx[s] = x; sy[s] = y; sw[s] = ww;
    sh[s] = hh; px[s] = ox; py[s] = oy;
  endtask

  task automatic rand_slot(input int s);
    int ww;
    ww = int'($urandom_range(16, 1));
    set_slot(s,
      int'($urandom_range(2400 - ww)),
      int'($urandom_range(150)),
      ww,
      int'($urandom_range(16, 1)),
      int'($urandom_range(W + 16)) - 16,
      int'($urandom_range(H + 16)) - 16);
  endtask

  task automatic load_slots;
    for (int i = 0; i < RS; i++) begin
      sprite[i] = {12'(sx[i]), 12'(sy[i]),
                   12'(sw[i]), 12'(sh[i])};
      pos[i]    = {12'(px[i]), 12'(py[i])};
    end
  endtask

  task automatic build_model;
    int x, y;
    pixel_t v;
    for (int p = 0; p < NPIX; p++) mdl[p] = BG_PIXEL;
    exp_draw = 0;
    sum_wh = 0;
    for (int s = 0; s < RS; s++) begin
      sum_wh += sw[s] * sh[s];
      for (int r = 0; r < sh[s]; r++)
        for (int c = 0; c < sw[s]; c++) begin
          x = px[s] + c;
          y = py[s] + r;
          if (x >= 0 && x < W && y >= 0 && y < H) begin
            v = rom_fn(AW'((sy[s] + r) * SW + sx[s] + c),
                       rom_mode);
            if (v != TRANSPARENT) begin
              mdl[y * W + x] = v;
              exp_draw++;
            end
          end
        end
    end
  endtask

  task automatic start_frame(output int t0, output int r0);
    @(negedge clk); #1 arm = ~arm;
    @(negedge clk); #1 frame_start = 1'b1;
    t0 = cyc;
    r0 = rises;
    @(negedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit poke);
    int t0, r0, n, bad, lat, lo, hi;
    bit poked;
    load_slots();
    build_model();
    start_frame(t0, r0);
    chk({tag, ":fin_low"}, painter_finished, 0);
    n = 0;
    poked = 0;
    while (!painter_finished && n < 20000) begin
      @(negedge clk); #1 n++;
      if (poke && !poked && wr_idx >= NPIX + 3) begin
        poked = 1;
        frame_start = 1'b1;
        @(negedge clk); #1 frame_start = 1'b0;
        n++;
      end
    end
    chk({tag, ":finished"}, painter_finished, 1);
    repeat (L + 4) @(negedge clk);
    #1;
    chk({tag, ":rise_count"}, rises - r0, 1);
    chk({tag, ":fin_stays"}, painter_finished, 1);
    chk({tag, ":clear"}, clr_bad, 0);
    chk({tag, ":writes"}, wr_idx, NPIX + exp_draw);
    chk({tag, ":oob"}, oob, 0);
    bad = 0;
    for (int p = 0; p < NPIX; p++)
      if (cap[p] !== mdl[p]) bad++;
    chk({tag, ":image_bad_px"}, bad, 0);
    lat = rise_cyc - t0 - 1;
    lo  = NPIX + sum_wh + L;
    hi  = lo + 3 * RS + 2;
    chk($sformatf("%s:latency=%0d in [%0d,%0d]",
                  tag, lat, lo, hi),
        (lat >= lo && lat <= hi), 1);
  endtask

  initial begin
    int t0, r0, n, stray;
    clear_slots();
    load_slots();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("reset:fb_we", fb_we, 0);
    chk("reset:fb_addr", fb_addr, 0);
    chk("reset:fb_data", fb_data, 0);
    chk("reset:rom_addr", rom_addr, 0);
    chk("reset:finished", painter_finished, 0);
    repeat (100) @(negedge clk);
    #1;
    chk("idle:writes", wr_idx, 0);
    chk("idle:finished", painter_finished, 0);

    clear_slots();
    rom_mode = 0;
    run_frame("empty", 0);

    clear_slots();
    set_slot(18, 1678, 2, 88, 50, 4, 10);
    run_frame("big", 0);
    chk("big:draw_writes", wr_idx - NPIX, 88 * 50);
    chk("big:first_addr", first_draw, 10 * W + 4);
    chk("big:last_addr", last_draw, 59 * W + 91);

    clear_slots();
    set_slot(3, 500, 20, 20, 20, -10, -5);
    set_slot(7, 600, 30, 20, 20, W - 5, H - 5);
    run_frame("clip", 0);
    chk("clip:draw_writes", wr_idx - NPIX, 10 * 15 + 5 * 5);

    clear_slots();
    rom_mode = 1;
    set_slot(0, 100, 5, 30, 24, 20, 10);
    set_slot(11, 1200, 7, 30, 24, 30, 20);
    for (int k = 0; k < 4; k++)
      rand_slot(int'($urandom_range(31, 12)));
    run_frame("overlap", 0);

    clear_slots();
    rom_mode = int'($urandom_range(1));
    for (int k = 0; k < 8; k++)
      rand_slot(int'($urandom_range(RS - 1)));
    run_frame("random", 0);

    clear_slots();
    rom_mode = 0;
    set_slot(5, 300, 10, 40, 40, 10, 10);
    load_slots();
    start_frame(t0, r0);
    n = 0;
    while (wr_idx < NPIX + 50 && n < 20000) begin
      @(negedge clk); #1 n++;
    end
    chk("abort:reached_draw", wr_idx >= NPIX + 50, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort:fb_we", fb_we, 0);
    chk("abort:finished", painter_finished, 0);
    stray = 0;
    for (int k = 0; k < L + 4; k++) begin
      @(negedge clk); #1;
      if (fb_we) stray++;
      if (k == 1) rst = 1'b0;
    end
    chk("abort:stray_writes", stray, 0);
    chk("abort:fin_after", painter_finished, 0);
    run_frame("refresh", 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
